// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives imem, and queues {pc, instr, fault}
// entries toward decode over a valid/ready handshake with redirect/flush support.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    FAULTED = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [31:0]     pc_r, pc_s;
  logic [AW:0]     count_r, count_s;
  logic [AW-1:0]   rd_ptr_r, rd_ptr_s;
  logic [AW-1:0]   wr_ptr_r, wr_ptr_s;
  logic [31:0]     q_pc_r    [DEPTH];
  logic [31:0]     q_instr_r [DEPTH];
  logic            q_fault_r [DEPTH];
  logic            push_s, pop_s, fault_s, fetching_s;

  assign imem_addr = pc_r;
  assign out_valid = (count_r != {(AW+1){1'b0}});
  assign out_pc    = q_pc_r[rd_ptr_r];
  assign out_instr = q_instr_r[rd_ptr_r];
  assign out_fault = q_fault_r[rd_ptr_r];

  // Next-state logic: redirect flushes everything; fullness uses the registered count.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    count_s  = count_r;
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    fault_s  = (pc_r >= PC_LIMIT);
    pop_s    = out_valid && out_ready;
    case (state_r)
      FETCH:   fetching_s = 1'b1;
      FAULTED: fetching_s = 1'b0;
      default: fetching_s = 1'b0;
    endcase
    push_s = fetching_s && (count_r < DEPTH_C) && !redirect_valid;

    if (redirect_valid) begin
      count_s  = {(AW+1){1'b0}};
      rd_ptr_s = {AW{1'b0}};
      wr_ptr_s = {AW{1'b0}};
      pc_s     = redirect_pc & 32'hFFFF_FFFC;
      state_s  = FETCH;
    end else begin
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + AW'(1);
        if (fault_s) begin
          state_s = FAULTED;
        end else begin
          pc_s = pc_r + 32'd4;
        end
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      count_s = count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end
  end

  // Control registers: state, PC, occupancy and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= FETCH;
      pc_r     <= RESET_PC;
      count_r  <= {(AW+1){1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      count_r  <= count_s;
      rd_ptr_r <= rd_ptr_s;
      wr_ptr_r <= wr_ptr_s;
    end
  end

  // Entry storage: out-of-range fetches enqueue a NOP tagged as a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_r[i]    <= 32'h0000_0000;
        q_instr_r[i] <= 32'h0000_0000;
        q_fault_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      q_pc_r[wr_ptr_r]    <= pc_r;
      q_instr_r[wr_ptr_r] <= fault_s ? NOP : imem_instr;
      q_fault_r[wr_ptr_r] <= fault_s;
    end
  end

endmodule
